// File: rtl/dice_pkg.sv
// Shared constants and helpers for the dice button conditioner.
package dice_pkg;

    localparam int NUM_BTN                = 6;
    localparam int DBNC_CNT_W             = 9;
    localparam int DEBOUNCE_TICKS_DEFAULT = 328;

    localparam int BTN_D4   = 0;
    localparam int BTN_D6   = 1;
    localparam int BTN_D8   = 2;
    localparam int BTN_D10  = 3;
    localparam int BTN_D20  = 4;
    localparam int BTN_D100 = 5;

    // Isolates the lowest set bit; zero in gives zero out.
    function automatic logic [NUM_BTN-1:0] lowest_one(input logic [NUM_BTN-1:0] v);
        return v & (~v + NUM_BTN'(1));
    endfunction

endpackage

// File: rtl/dice_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter, accepted level
// and rise detect. stable_nxt/rise describe the value stable takes at this edge.
module dice_debounce_ch
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable_nxt,
    output logic rise
);

    localparam logic [DBNC_CNT_W-1:0] CNT_LAST = DBNC_CNT_W'(DEBOUNCE_TICKS - 1);

    logic                  s1_q;
    logic                  s2_q;
    logic                  stable_q;
    logic                  stable_d;
    logic [DBNC_CNT_W-1:0] cnt_q;
    logic [DBNC_CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals; no latch is inferred.
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + DBNC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so s1->s2 shifts rather than collapsing in one edge.
            s1_q     <= raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_nxt = stable_d;
    assign rise       = stable_d & ~stable_q;

endmodule

// File: rtl/dice_button_conditioner.sv
// Debounces the six die-select buttons into registered levels and press pulses.
// Define DICE_BTN_LOCKOUT_EN to admit only one button at a time.
module dice_button_conditioner
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               btn_any
);

    logic [NUM_BTN-1:0] stable_nxt;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] level_q;
    logic [NUM_BTN-1:0] level_d;
    logic [NUM_BTN-1:0] press_q;
    logic [NUM_BTN-1:0] press_d;
    logic               any_q;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        dice_debounce_ch #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .raw       (btn_raw[i]),
            .stable_nxt(stable_nxt[i]),
            .rise      (rise[i])
        );
    end

`ifdef DICE_BTN_LOCKOUT_EN
    logic [NUM_BTN-1:0] grant_q;
    logic [NUM_BTN-1:0] grant_d;

    // Grant is free when nothing is held or the holder is being released;
    // held buttons stay masked because they produce no new rise.
    always_comb begin
        grant_d = grant_q;
        if ((stable_nxt & grant_q) == '0) begin
            grant_d = lowest_one(rise);
        end
        level_d = stable_nxt & grant_d;
        press_d = rise & grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= '0;
        end else begin
            grant_q <= grant_d;
        end
    end
`else
    always_comb begin
        level_d = stable_nxt;
        press_d = rise;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            press_q <= '0;
            any_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            press_q <= press_d;
            any_q   <= |level_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
    assign btn_any   = any_q;

endmodule

// File: tb/tb_dice_button_conditioner.sv
// Self-checking bench for dice_button_conditioner with DEBOUNCE_TICKS=4,
// using a sliding-window reference model of the accepted button levels.
module tb_dice_button_conditioner;
    import dice_pkg::*;

    localparam int T = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic               btn_any;

    int n_vec = 0;
    int n_err = 0;

    // Model: raw values sampled at the last T+2 edges, newest at index 0.
    logic [NUM_BTN-1:0] hist [0:T+1];
    logic [NUM_BTN-1:0] m_stable;
    logic [NUM_BTN-1:0] m_grant;
    logic [NUM_BTN-1:0] m_level;
    logic [NUM_BTN-1:0] m_press;

    always #5 clk = ~clk;

    dice_button_conditioner #(
        .DEBOUNCE_TICKS(T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_any  (btn_any)
    );

    task automatic model_reset();
        for (int i = 0; i <= T + 1; i++) hist[i] = '0;
        m_stable = '0;
        m_grant  = '0;
        m_level  = '0;
        m_press  = '0;
    endtask

    // A channel flips once the value seen through the two-stage synchroniser
    // has disagreed with the accepted level for T consecutive edges.
    task automatic model_edge(input logic [NUM_BTN-1:0] raw);
        logic [NUM_BTN-1:0] rose;
        bit                 all_differ;
        rose = '0;
        for (int i = T + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = raw;
        for (int c = 0; c < NUM_BTN; c++) begin
            all_differ = 1'b1;
            for (int j = 2; j <= T + 1; j++) begin
                if (hist[j][c] == m_stable[c]) all_differ = 1'b0;
            end
            if (all_differ) begin
                m_stable[c] = ~m_stable[c];
                if (m_stable[c]) rose[c] = 1'b1;
            end
        end
`ifdef DICE_BTN_LOCKOUT_EN
        if ((m_stable & m_grant) == '0) begin
            m_grant = '0;
            for (int c = 0; c < NUM_BTN; c++) begin
                if (rose[c] && m_grant == '0) m_grant[c] = 1'b1;
            end
        end
        m_level = m_stable & m_grant;
        m_press = rose & m_grant;
`else
        m_level = m_stable;
        m_press = rose;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(btn_raw);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b1;
        btn_raw = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({btn_level, btn_press, btn_any} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_async got level=%h press=%h any=%b expected all zero",
                     btn_level, btn_press, btn_any);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            n_vec++;
            if ({btn_level, btn_press, btn_any} !== 13'd0) begin
                n_err++;
                $display("FAIL reset_hold got level=%h press=%h any=%b expected all zero",
                         btn_level, btn_press, btn_any);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic settle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            step();
            n_vec++;
            if ({btn_level, btn_press, btn_any} !== {m_level, m_press, |m_level}) begin
                n_err++;
                $display("FAIL %s cyc=%0d got level=%h press=%h any=%b expected level=%h press=%h any=%b",
                         tag, c, btn_level, btn_press, btn_any, m_level, m_press, |m_level);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [NUM_BTN-1:0] exp_level;
        logic [NUM_BTN-1:0] exp_press;
        btn_raw = NUM_BTN'(1) << BTN_D6;
        for (int c = 1; c <= T + 4; c++) begin
            step();
            exp_level = (c >= T + 2) ? 6'h02 : 6'h00;
            exp_press = (c == T + 2) ? 6'h02 : 6'h00;
            n_vec++;
            if ({btn_level, btn_press, btn_any} !== {exp_level, exp_press, exp_level != 0}) begin
                n_err++;
                $display("FAIL clean_press cyc=%0d got level=%h press=%h any=%b expected level=%h press=%h any=%b",
                         c, btn_level, btn_press, btn_any, exp_level, exp_press, exp_level != 0);
            end
        end
        btn_raw = '0;
        settle("clean_release", T + 3);
    endtask

    task automatic test_bounce();
        int pulses;
        int pulse_at;
        pulses   = 0;
        pulse_at = -1;
        for (int s = 0; s < 8 + T + 6; s++) begin
            btn_raw[BTN_D4] = (s >= 8) ? 1'b1 : ((s / 2) % 2 == 0);
            step();
            n_vec++;
            if ({btn_level, btn_press} !== {m_level, m_press}) begin
                n_err++;
                $display("FAIL bounce step=%0d got level=%h press=%h expected level=%h press=%h",
                         s, btn_level, btn_press, m_level, m_press);
            end
            if (btn_press[BTN_D4]) begin
                pulses++;
                pulse_at = s;
            end
        end
        n_vec++;
        if (pulses != 1 || pulse_at != 8 + T + 1) begin
            n_err++;
            $display("FAIL bounce_pulse got count=%0d at=%0d expected count=1 at=%0d",
                     pulses, pulse_at, 8 + T + 1);
        end
        btn_raw = '0;
        settle("bounce_release", T + 3);
    endtask

    task automatic test_glitch();
        for (int s = 0; s < 12; s++) begin
            btn_raw[BTN_D100] = (s < 3);
            step();
            n_vec++;
            if ({btn_level, btn_press} !== 12'd0 || m_level !== 6'h00) begin
                n_err++;
                $display("FAIL glitch step=%0d got level=%h press=%h model=%h expected level=00 press=00",
                         s, btn_level, btn_press, m_level);
            end
        end
    endtask

    task automatic test_release();
        logic [NUM_BTN-1:0] exp_level;
        btn_raw = NUM_BTN'(1) << BTN_D10;
        settle("release_press", T + 3);
        btn_raw = '0;
        for (int c = 1; c <= T + 4; c++) begin
            step();
            exp_level = (c < T + 2) ? 6'h08 : 6'h00;
            n_vec++;
            if ({btn_level, btn_press} !== {exp_level, 6'h00}) begin
                n_err++;
                $display("FAIL release cyc=%0d got level=%h press=%h expected level=%h press=00",
                         c, btn_level, btn_press, exp_level);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NUM_BTN-1:0] exp_level;
        logic [NUM_BTN-1:0] exp_press;
        btn_raw = NUM_BTN'(1) << BTN_D8;
        settle("mid_press", T + 3);
        n_vec++;
        if (btn_level !== 6'h04) begin
            n_err++;
            $display("FAIL mid_pre_reset got level=%h expected level=04", btn_level);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if ({btn_level, btn_press, btn_any} !== 13'd0) begin
            n_err++;
            $display("FAIL mid_reset_async got level=%h press=%h any=%b expected all zero",
                     btn_level, btn_press, btn_any);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= T + 4; c++) begin
            step();
            exp_level = (c >= T + 2) ? 6'h04 : 6'h00;
            exp_press = (c == T + 2) ? 6'h04 : 6'h00;
            n_vec++;
            if ({btn_level, btn_press} !== {exp_level, exp_press}) begin
                n_err++;
                $display("FAIL mid_reaccept cyc=%0d got level=%h press=%h expected level=%h press=%h",
                         c, btn_level, btn_press, exp_level, exp_press);
            end
        end
        btn_raw = '0;
        settle("mid_release", T + 3);
    endtask

    task automatic test_simultaneous();
        logic [NUM_BTN-1:0] exp_both;
`ifdef DICE_BTN_LOCKOUT_EN
        exp_both = 6'h04;
`else
        exp_both = 6'h14;
`endif
        btn_raw = 6'h14;
        settle("simul_wait", T + 1);
        step();
        n_vec++;
        if ({btn_level, btn_press} !== {exp_both, exp_both}) begin
            n_err++;
            $display("FAIL simul_press got level=%h press=%h expected level=%h press=%h",
                     btn_level, btn_press, exp_both, exp_both);
        end
        settle("simul_hold", 2);
`ifdef DICE_BTN_LOCKOUT_EN
        btn_raw = 6'h10;
        settle("lock_release2", T + 3);
        n_vec++;
        if (btn_level !== 6'h00) begin
            n_err++;
            $display("FAIL lock_masked got level=%h expected level=00", btn_level);
        end
        btn_raw = 6'h00;
        settle("lock_release4", T + 3);
        btn_raw = 6'h10;
        settle("lock_repress4", T + 3);
        n_vec++;
        if (btn_level !== 6'h10) begin
            n_err++;
            $display("FAIL lock_regrant got level=%h expected level=10", btn_level);
        end
`endif
        btn_raw = '0;
        settle("simul_release", T + 3);
    endtask

    task automatic test_random();
        for (int s = 0; s < 600; s++) begin
            if ($urandom_range(0, 4) == 0) btn_raw[$urandom_range(0, NUM_BTN - 1)] ^= 1'b1;
            step();
            n_vec++;
            if ({btn_level, btn_press, btn_any} !== {m_level, m_press, |m_level}) begin
                n_err++;
                $display("FAIL random step=%0d raw=%h got level=%h press=%h any=%b expected level=%h press=%h any=%b",
                         s, btn_raw, btn_level, btn_press, btn_any, m_level, m_press, |m_level);
            end
        end
        btn_raw = '0;
        settle("random_release", T + 3);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
